// File: rtl/gray_in_pkg.sv
// Shared definitions for the gray camera formatter: FSM state type,
// output word layout and counter sizing helper.
package gray_in_pkg;

  // Frame-level states of the formatter
  typedef enum logic [1:0] {
    ST_WAIT_VSYNC,
    ST_WAIT_FRAME,
    ST_ACTIVE,
    ST_DROP
  } state_e;

  // Output word layout: {sof, byte1, byte0}
  localparam int unsigned SOF_BIT = 16;
  localparam int unsigned WORD_W  = 17;

  // Counter width for a count range of n, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray_byte_packer.sv
// Byte-pair packer: the first byte of a pair goes to [7:0], the second to
// [15:8]; the finished word is registered together with the SOF flag.
// With GRAY_TEST_PATTERN_EN defined the payload is replaced by a 16-bit
// counter that restarts at 0 on the SOF word.
module gray_byte_packer
  import gray_in_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_en_i,
  input  logic              phase_clr_i,
  input  logic              sof_i,
  output logic              pair_done_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  logic              phase_q;
  logic [7:0]        low_q;
  logic              valid_q;
  logic [WORD_W-1:0] word_q;
`ifdef GRAY_TEST_PATTERN_EN
  logic [15:0]       pat_q;
`endif

  // A byte accepted while holding the low half completes a word this cycle
  assign pair_done_o  = byte_en_i && phase_q;
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

  // Pair phase, low-byte holding register and registered output word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= 1'b0;
      low_q   <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
`ifdef GRAY_TEST_PATTERN_EN
      pat_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (phase_clr_i) begin
        // an odd trailing byte is simply forgotten here
        phase_q <= 1'b0;
      end else if (byte_en_i) begin
        if (!phase_q) begin
          low_q   <= byte_i;
          phase_q <= 1'b1;
        end else begin
          phase_q         <= 1'b0;
          valid_q         <= 1'b1;
          word_q[SOF_BIT] <= sof_i;
`ifdef GRAY_TEST_PATTERN_EN
          if (sof_i) begin
            word_q[15:0] <= '0;
            pat_q        <= 16'd1;
          end else begin
            word_q[15:0] <= pat_q;
            pat_q        <= pat_q + 16'd1;
          end
`else
          word_q[15:0] <= {byte_i, low_q};
`endif
        end
      end
    end
  end

endmodule

// File: rtl/gray_cam_formatter.sv
// Gray camera formatter: registers the camera bus, tracks frames with a
// vsync-driven FSM, crops lines/words to the configured frame size and packs
// byte pairs into 17-bit {sof, byte1, byte0} words for a DDR3 writer.
// Optional feature macro: GRAY_TEST_PATTERN_EN (counter payload).
module gray_cam_formatter
  import gray_in_pkg::*;
#(
  parameter int unsigned frame_width = 768,
  parameter int unsigned frame_lines = 480
) (
  input  logic              pclk,
  input  logic              pclk_reset,
  input  logic [7:0]        cam_data,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic              fifo_almost_full,
  output logic [WORD_W-1:0] pixel_data,
  output logic              pixel_valid,
  output logic              frame_dropped,
  output logic              overflow_err
);

  localparam int unsigned WW = cnt_width(frame_width);
  localparam int unsigned LW = cnt_width(frame_lines);
  localparam logic [WW-1:0] W_LAST = WW'(frame_width - 1);
  localparam logic [LW-1:0] L_LAST = LW'(frame_lines - 1);

  logic [7:0]    data_q;
  logic          href_q;
  logic          vsync_q;
  logic          href_prev_q;
  logic          vsync_prev_q;

  state_e        state_q;
  logic          frame_dropped_q;
  logic          overflow_q;

  logic [WW-1:0] word_cnt_q;
  logic [LW-1:0] line_cnt_q;
  logic          line_full_q;
  logic          lines_done_q;

  logic          vs_rise;
  logic          vs_fall;
  logic          href_fall;
  logic          byte_en;
  logic          phase_clr;
  logic          sof;
  logic          pair_done;
  logic          word_valid;
  logic [WORD_W-1:0] word;

  // Input capture plus one-cycle history for edge detection
  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      data_q       <= '0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      href_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      data_q       <= cam_data;
      href_q       <= cam_href;
      vsync_q      <= cam_vsync;
      href_prev_q  <= href_q;
      vsync_prev_q <= vsync_q;
    end
  end

  assign vs_rise   = vsync_q && !vsync_prev_q;
  assign vs_fall   = !vsync_q && vsync_prev_q;
  assign href_fall = !href_q && href_prev_q;

  // Frame FSM; the accept/drop decision is taken when vsync falls
  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      state_q         <= ST_WAIT_VSYNC;
      frame_dropped_q <= 1'b0;
    end else begin
      frame_dropped_q <= 1'b0;
      case (state_q)
        ST_WAIT_VSYNC: begin
          if (vsync_q) state_q <= ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: begin
          if (vs_fall) begin
            if (fifo_almost_full) begin
              state_q         <= ST_DROP;
              frame_dropped_q <= 1'b1;
            end else begin
              state_q <= ST_ACTIVE;
            end
          end
        end
        ST_ACTIVE, ST_DROP: begin
          if (vs_rise) state_q <= ST_WAIT_FRAME;
        end
        default: state_q <= ST_WAIT_VSYNC;
      endcase
    end
  end

  // Bytes are taken only inside an accepted frame and within the crop window
  assign byte_en   = (state_q == ST_ACTIVE) && href_q && !vsync_q &&
                     !line_full_q && !lines_done_q;
  assign phase_clr = !href_q || (state_q != ST_ACTIVE);
  assign sof       = (line_cnt_q == '0) && (word_cnt_q == '0);

  // Word/line position; saturation flags replace wrap at the last index
  always_ff @(posedge pclk) begin
    if (pclk_reset || state_q != ST_ACTIVE) begin
      word_cnt_q   <= '0;
      line_cnt_q   <= '0;
      line_full_q  <= 1'b0;
      lines_done_q <= 1'b0;
    end else if (href_fall) begin
      word_cnt_q  <= '0;
      line_full_q <= 1'b0;
      if (!lines_done_q) begin
        if (line_cnt_q == L_LAST) lines_done_q <= 1'b1;
        else                      line_cnt_q   <= line_cnt_q + 1'b1;
      end
    end else if (pair_done) begin
      if (word_cnt_q == W_LAST) line_full_q <= 1'b1;
      else                      word_cnt_q  <= word_cnt_q + 1'b1;
    end
  end

  // Sticky flag for a word presented while the downstream FIFO is nearly full
  always_ff @(posedge pclk) begin
    if (pclk_reset)                          overflow_q <= 1'b0;
    else if (word_valid && fifo_almost_full) overflow_q <= 1'b1;
  end

  gray_byte_packer u_packer (
    .clk_i        (pclk),
    .rst_i        (pclk_reset),
    .byte_i       (data_q),
    .byte_en_i    (byte_en),
    .phase_clr_i  (phase_clr),
    .sof_i        (sof),
    .pair_done_o  (pair_done),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  assign pixel_data    = word;
  assign pixel_valid   = word_valid;
  assign frame_dropped = frame_dropped_q;
  assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_gray_cam_formatter.sv
// Scoreboard bench for gray_cam_formatter: frames are described as byte
// arrays, a frame-level model pushes the expected words, a monitor pops them.
module tb_gray_cam_formatter;

  localparam int W = 4;
  localparam int L = 2;

  logic        pclk = 1'b0;
  logic        pclk_reset = 1'b1;
  logic [7:0]  cam_data = '0;
  logic        cam_href = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic [16:0] pixel_data;
  logic        pixel_valid;
  logic        frame_dropped;
  logic        overflow_err;

  logic [16:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          drop_cycles = 0;
  int          exp_drops = 0;
  logic [15:0] pat = '0;

  int          line_len[4];
  logic [7:0]  line_bytes[4][24];

  gray_cam_formatter #(.frame_width(W), .frame_lines(L)) dut (
    .pclk             (pclk),
    .pclk_reset       (pclk_reset),
    .cam_data         (cam_data),
    .cam_href         (cam_href),
    .cam_vsync        (cam_vsync),
    .fifo_almost_full (fifo_almost_full),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .frame_dropped    (frame_dropped),
    .overflow_err     (overflow_err)
  );

  always #5 pclk = ~pclk;

  // Monitor: every presented word is matched against the scoreboard head
  always @(negedge pclk) begin
    if (!pclk_reset) begin
      if (pixel_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word: got %h, expected no word", pixel_data);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if (pixel_data !== e) begin
            errors++;
            $display("FAIL word: got %h, expected %h", pixel_data, e);
          end
        end
      end
      if (frame_dropped) drop_cycles++;
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    pclk_reset = 1'b1;
    cam_href = 1'b0;
    cam_vsync = 1'b0;
    fifo_almost_full = 1'b0;
    repeat (3) tick();
    pclk_reset = 1'b0;
    pat = '0;
  endtask

  task automatic set_line(input int l, input int len, input int start);
    line_len[l] = len;
    for (int i = 0; i < len; i++) line_bytes[l][i] = 8'(start + i);
  endtask

  task automatic rand_line(input int l, input int len);
    line_len[l] = len;
    for (int i = 0; i < len; i++) line_bytes[l][i] = 8'($urandom);
  endtask

  // Frame-level model: words per line = min(bytes/2, W), only the first L lines
  task automatic model_frame(input int nl, input bit drop);
    if (drop) begin
      exp_drops++;
      return;
    end
    for (int l = 0; l < nl && l < L; l++) begin
      int nw;
      nw = line_len[l] / 2;
      if (nw > W) nw = W;
      for (int k = 0; k < nw; k++) begin
        bit sof;
        logic [15:0] d;
        sof = (l == 0) && (k == 0);
`ifdef GRAY_TEST_PATTERN_EN
        if (sof) pat = '0;
        d = pat;
        pat = pat + 16'd1;
`else
        d = {line_bytes[l][2*k+1], line_bytes[l][2*k]};
`endif
        exp_q.push_back({sof, d});
      end
    end
  endtask

  // Drive one frame; ovf_byte >= 0 raises fifo_almost_full at that byte of line 0
  task automatic send_frame(input int nl, input bit drop, input int ovf_byte);
    model_frame(nl, drop);
    cam_vsync = 1'b1;
    fifo_almost_full = drop;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    fifo_almost_full = 1'b0;
    for (int l = 0; l < nl; l++) begin
      cam_href = 1'b1;
      for (int i = 0; i < line_len[l]; i++) begin
        if (l == 0 && i == ovf_byte) fifo_almost_full = 1'b1;
        cam_data = line_bytes[l][i];
        tick();
      end
      cam_href = 1'b0;
      cam_data = '0;
      repeat (3) tick();
    end
    repeat (2) tick();
    fifo_almost_full = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    do_reset();
    tick();
    check("rst_valid", {31'd0, pixel_valid}, 32'd0);
    check("rst_data", {15'd0, pixel_data}, 32'd0);
    check("rst_dropped", {31'd0, frame_dropped}, 32'd0);
    check("rst_ovf", {31'd0, overflow_err}, 32'd0);

    // bytes 0x01..0x10 over two 8-byte lines
    set_line(0, 8, 1);
    set_line(1, 8, 9);
    send_frame(2, 1'b0, -1);
    wait_drain();

    // dropped frame followed by an accepted one
    set_line(0, 8, 8'h20);
    set_line(1, 8, 8'h30);
    send_frame(2, 1'b1, -1);
    check("drop_pulse", 32'(drop_cycles), 32'(exp_drops));
    send_frame(2, 1'b0, -1);
    wait_drain();

    // odd 9-byte line and a 20-byte line cropped to W words
    set_line(0, 9, 8'h40);
    set_line(1, 20, 8'h60);
    send_frame(2, 1'b0, -1);
    wait_drain();

    // backpressure arriving on the third word; frame still completes
    check("ovf_before", {31'd0, overflow_err}, 32'd0);
    set_line(0, 8, 8'h80);
    set_line(1, 8, 8'h90);
    send_frame(2, 1'b0, 4);
    wait_drain();
    check("ovf_set", {31'd0, overflow_err}, 32'd1);

    // randomized frames: 1..3 lines (third line beyond crop), 1..20 bytes
    for (int f = 0; f < 20; f++) begin
      int nl;
      nl = $urandom_range(3, 1);
      for (int l = 0; l < nl; l++) rand_line(l, $urandom_range(20, 1));
      send_frame(nl, ($urandom_range(3, 0) == 0), -1);
    end
    wait_drain();
    check("ovf_sticky", {31'd0, overflow_err}, 32'd1);
    check("drop_count", 32'(drop_cycles), 32'(exp_drops));

    // reset in the middle of line 0: the rest of that frame is discarded
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    cam_href = 1'b1;
    cam_data = 8'hA1;
    tick();
    pclk_reset = 1'b1;
    cam_data = 8'hA2;
    tick();
    cam_data = 8'hA3;
    tick();
    pclk_reset = 1'b0;
    pat = '0;
    check("mid_rst_ovf", {31'd0, overflow_err}, 32'd0);
    check("mid_rst_valid", {31'd0, pixel_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cam_data = 8'(8'hA4 + i);
      tick();
    end
    cam_href = 1'b0;
    repeat (3) tick();
    set_line(0, 8, 8'hC0);
    set_line(1, 6, 8'hD0);
    send_frame(2, 1'b0, -1);
    wait_drain();
    check("final_drops", 32'(drop_cycles), 32'(exp_drops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
